ps2_keycode_rx: RTL
===================

// Module: ps2_keycode_rx
// PURPOSE
//  Receives PS/2 keyboard frames (scan-code set 2) and presents a held-key HID-style keycode.
//  The keycode is the one the doodle motion logic consumes: 8'h04 = A, 8'h07 = D.
//  Sits between the board PS/2 pins and the game logic, in the 50 MHz Clk domain.
//  Handles make, break (F0) and extended (E0) prefixes, parity and stop checks, and frame timeout.
// PARAMETERS
//  FILTER_LEN   8      consecutive equal synced samples required to accept a ps2_clk level change
//  TIMEOUT_CYC  50000  Clk cycles with no ps2_clk fall mid-frame before the frame is abandoned (1 ms)
// PORTS
//  Clk         in   1  50 MHz system clock
//  Reset_n     in   1  asynchronous, active-low reset
//  ps2_clk     in   1  raw PS/2 clock pin (async, open-drain, idle high)
//  ps2_data    in   1  raw PS/2 data pin (async, idle high)
//  keycode     out  8  HID code of the currently held mapped key; 8'h00 = none
//  scan_code   out  8  last good raw scan byte
//  scan_valid  out  1  one-Clk pulse per good frame; scan_code is valid on that cycle
//  frame_err   out  1  one-Clk pulse on parity error, stop error or timeout
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0; FSM in IDLE; prefix flags clear; filter reads high.
//  Input path: ps2_clk and ps2_data pass through a 2-flop synchronizer.
//   - Filtered clock changes only after FILTER_LEN identical synced samples.
//   - fall = 1-cycle pulse when the filtered clock goes 1->0; data is sampled on the fall cycle.
//  Frame FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE.
//   - IDLE: on fall with data=0 (start bit), go to DATA with bit_cnt=0. Start bit of 1 is ignored; stay in IDLE.
//   - DATA: on each fall, shift data in LSB first; after the 8th bit go to PARITY.
//   - PARITY: on fall, capture the parity bit; go to STOP.
//   - STOP: on fall, the frame is good if the stop bit is 1 and ^{byte,parity} == 1 (odd parity).
//     Good frame: scan_code and scan_valid update the Clk after the stop fall cycle.
//     Bad frame: frame_err pulses instead of scan_valid.
//     Either way, return to IDLE.
//  Timeout: a counter clears on every fall and counts while not in IDLE.
//   - At TIMEOUT_CYC: frame_err pulses, FSM goes to IDLE, partial byte is discarded, prefix flags clear.
//  Decode (only on scan_valid cycles):
//   - E0 sets ext; F0 sets brk; neither changes keycode.
//   - Any other byte: map {ext, byte} to a HID code, then clear ext and brk.
//   - Map: 1C->04 (A), 23->07 (D), 1D->1A (W), 1B->16 (S), 29->2C (space), E0 6B->50 (left), E0 74->4F (right).
//     Every other byte maps to 00.
//   - Make of a mapped key: keycode <= mapped code, on the same cycle as scan_valid.
//   - Make of an unmapped key: keycode unchanged.
//   - Break (brk=1): keycode <= 00 only if the mapped code equals the current keycode; otherwise unchanged.
//   - Typematic repeat (same make again): keycode stays the same.
//   - A frame_err clears ext and brk but leaves keycode unchanged.
//  Latency: stop-bit fall cycle + 1 Clk -> scan_valid and keycode; pin-to-fall adds 2 + FILTER_LEN Clk.
//  Simultaneous events: a fall on the same cycle the timeout is reached counts as the fall; no timeout.
//  Reset mid-frame: the partial frame is discarded; the next frame must start from a fresh start bit.
// TESTING
//  1. Send 1C at a 12 kHz bit rate -> scan_valid pulses once, scan_code=1C, keycode=04.
//  2. Send 1C, then F0 1C -> keycode 04, then 00 after the 1C following F0; F0 produces no keycode change.
//  3. Send 23 with even parity -> frame_err pulses once, no scan_valid, keycode unchanged; next good 23 -> 07.
//  4. Send E0 6B -> keycode=50; then E0 F0 6B -> keycode=00.
//  5. Hold D (keycode=07), send make 1C then break 23 -> keycode=04 and stays 04.
//  6. Send 5 bits then stop toggling ps2_clk for TIMEOUT_CYC+10 cycles -> frame_err pulses, FSM is IDLE.
//     A following full 1C frame -> keycode=04.
//  7. Pulse Reset_n low mid-byte -> outputs 0 immediately; next full frame decodes correctly.
//  8. Inject 3-cycle glitches on ps2_clk (< FILTER_LEN) -> no bit shifted, no scan_valid.

Source files
------------

// File: rtl/ps2_keycode_rx_if.sv
// ps2_keycode_rx_if: PS/2 pin pair plus the decoded keycode/scan-code outputs of the receiver.
//  ps2_clk, ps2_data        raw PS/2 pins (idle high)
//  keycode                  HID code of the currently held mapped key, 8'h00 = none
//  scan_code, scan_valid    last good raw scan byte and its one-cycle strobe
//  frame_err                one-cycle strobe on parity, stop or timeout error
// The receiver uses the slave modport; the keyboard side (board pins / testbench) uses master.
interface ps2_keycode_rx_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] keycode;
   logic [7:0] scan_code;
   logic       scan_valid;
   logic       frame_err;
   modport master (output ps2_clk, ps2_data, input keycode, scan_code, scan_valid, frame_err);
   modport slave  (input ps2_clk, ps2_data, output keycode, scan_code, scan_valid, frame_err);
endinterface

// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx: PS/2 set-2 frame receiver producing a held-key HID keycode for the motion logic.
//  Clk        50 MHz system clock
//  Reset_n    asynchronous active-low reset
//  bus        ps2_keycode_rx_if.slave: ps2_clk/ps2_data in; keycode, scan_code, scan_valid, frame_err out
// Parameters: FILTER_LEN synced samples needed to accept a ps2_clk level change,
//             TIMEOUT_CYC idle Clk cycles mid-frame before the frame is abandoned.
module ps2_keycode_rx #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input logic             Clk,
   input logic             Reset_n,
   ps2_keycode_rx_if.slave bus
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   state_t        state;
   logic [1:0]    clk_sync;
   logic [1:0]    dat_sync;
   logic          flt_clk;
   logic [FW-1:0] flt_cnt;
   logic          fall;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par;
   logic [TW-1:0] to_cnt;
   logic          ext;
   logic          brk;
   logic [7:0]    map_code;
   // Synchronizers and glitch filter; pins idle high so everything resets high.
   // fall is registered together with the filtered level so it lines up with the new low level.
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         flt_clk  <= 1'b1;
         flt_cnt  <= '0;
         fall     <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[0], bus.ps2_clk};
         dat_sync <= {dat_sync[0], bus.ps2_data};
         fall     <= 1'b0;
         if (clk_sync[1] == flt_clk)
            flt_cnt <= '0;
         else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
            flt_clk <= clk_sync[1];
            flt_cnt <= '0;
            fall    <= flt_clk;
         end else
            flt_cnt <= flt_cnt + 1'b1;
      end
   // Extended codes only match with the E0 prefix seen; plain codes only without it.
   always_comb
      map_code = ({ext, shreg} == 9'h01C) ? 8'h04 :
                 ({ext, shreg} == 9'h023) ? 8'h07 :
                 ({ext, shreg} == 9'h01D) ? 8'h1A :
                 ({ext, shreg} == 9'h01B) ? 8'h16 :
                 ({ext, shreg} == 9'h029) ? 8'h2C :
                 ({ext, shreg} == 9'h16B) ? 8'h50 :
                 ({ext, shreg} == 9'h174) ? 8'h4F : 8'h00;
   // Frame FSM, timeout and key decode. A fall always wins over a coincident timeout.
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         state          <= IDLE;
         bit_cnt        <= '0;
         shreg          <= '0;
         par            <= 1'b0;
         to_cnt         <= '0;
         ext            <= 1'b0;
         brk            <= 1'b0;
         bus.keycode    <= '0;
         bus.scan_code  <= '0;
         bus.scan_valid <= 1'b0;
         bus.frame_err  <= 1'b0;
      end else begin
         bus.scan_valid <= 1'b0;
         bus.frame_err  <= 1'b0;
         if (fall) begin
            to_cnt <= '0;
            case (state)
               IDLE: if (!dat_sync[1]) begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end
               DATA: begin
                  shreg   <= {dat_sync[1], shreg[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  state   <= (bit_cnt == 3'd7) ? PARITY : DATA;
               end
               PARITY: begin
                  par   <= dat_sync[1];
                  state <= STOP;
               end
               default: begin
                  state <= IDLE;
                  if (dat_sync[1] && ^{shreg, par}) begin
                     bus.scan_valid <= 1'b1;
                     bus.scan_code  <= shreg;
                     if (shreg == 8'hE0)
                        ext <= 1'b1;
                     else if (shreg == 8'hF0)
                        brk <= 1'b1;
                     else begin
                        // A break only releases the key that is actually held.
                        if (brk)
                           bus.keycode <= (map_code == bus.keycode) ? 8'h00 : bus.keycode;
                        else if (map_code != 8'h00)
                           bus.keycode <= map_code;
                        ext <= 1'b0;
                        brk <= 1'b0;
                     end
                  end else begin
                     bus.frame_err <= 1'b1;
                     ext           <= 1'b0;
                     brk           <= 1'b0;
                  end
               end
            endcase
         end else if (state == IDLE)
            to_cnt <= '0;
         else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
            bus.frame_err <= 1'b1;
            state         <= IDLE;
            to_cnt        <= '0;
            ext           <= 1'b0;
            brk           <= 1'b0;
         end else
            to_cnt <= to_cnt + 1'b1;
      end
endmodule
